// File: rtl/accel_sample_ctrl.sv
// Accelerometer SPI sequencer: writes the three-entry init table once, then issues
// periodic 6-byte burst reads of DATAX0..DATAZ1 and publishes X/Y/Z samples.
module accel_sample_ctrl #(
  parameter int unsigned SAMPLE_DIV = 50000,
  parameter int unsigned TIMEOUT    = 4095,
  parameter logic [7:0]  FORMAT_VAL = 8'h0B,
  parameter logic [7:0]  RATE_VAL   = 8'h0F,
  parameter logic [7:0]  POWER_VAL  = 8'h08
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        spi_enable,
  output logic        spi_rw,
  output logic [5:0]  spi_address,
  output logic [7:0]  spi_value,
  input  logic [55:0] spi_buffer,
  input  logic        spi_ready,
  output logic [15:0] sample_x,
  output logic [15:0] sample_y,
  output logic [15:0] sample_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        busy,
  output logic [7:0]  overrun_count,
  output logic        error
);

  localparam int unsigned TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned PW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(SAMPLE_DIV - 1);
  localparam logic [PW-1:0] PHASE_MAX = PW'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_ISSUE       = 3'd1;
  localparam logic [2:0] ST_WAIT_RDY    = 3'd2;
  localparam logic [2:0] ST_RELEASE     = 3'd3;
  localparam logic [2:0] ST_SAMPLE_WAIT = 3'd4;
  localparam logic [2:0] ST_FAULT       = 3'd5;

  logic [2:0]    state_r, state_n;
  logic [1:0]    idx_r, idx_n;
  logic [TW-1:0] timer_r, timer_n;
  logic [PW-1:0] phase_r, phase_n;
  logic          pending_r, pending_n;
  logic          enable_r, enable_n, rw_r, rw_n;
  logic [5:0]    addr_r, addr_n;
  logic [7:0]    value_r, value_n, overrun_r, overrun_n;
  logic [15:0]   x_r, x_n, y_r, y_n, z_r, z_n;
  logic          valid_r, valid_n, init_done_r, init_done_n;
  logic          error_r, error_n, busy_r, busy_n;
  logic          tick_s, wrap_s, pend_clear_s;
  logic          buf_unused_s;

  assign buf_unused_s = ^spi_buffer[55:48];

  function automatic logic [5:0] init_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    init_addr = 6'h31;
      2'd1:    init_addr = 6'h2C;
      default: init_addr = 6'h2D;
    endcase
  endfunction

  function automatic logic [7:0] init_value(input logic [1:0] idx);
    case (idx)
      2'd0:    init_value = FORMAT_VAL;
      2'd1:    init_value = RATE_VAL;
      default: init_value = POWER_VAL;
    endcase
  endfunction

  // Next-state, command, capture and sample-timer logic
  always_comb begin
    state_n      = state_r;
    idx_n        = idx_r;
    phase_n      = phase_r;
    enable_n     = enable_r;
    rw_n         = rw_r;
    addr_n       = addr_r;
    value_n      = value_r;
    x_n          = x_r;
    y_n          = y_r;
    z_n          = z_r;
    valid_n      = 1'b0;
    init_done_n  = init_done_r;
    error_n      = error_r;
    pend_clear_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run && !error_r) begin
          if (!init_done_r) begin
            state_n  = ST_ISSUE;
            enable_n = 1'b1;
            rw_n     = 1'b0;
            addr_n   = init_addr(idx_r);
            value_n  = init_value(idx_r);
          end else begin
            state_n = ST_SAMPLE_WAIT;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_n = ST_WAIT_RDY;
        phase_n = '0;
      end
      ST_WAIT_RDY: begin
        if (spi_ready) begin
          enable_n = 1'b0;
          state_n  = ST_RELEASE;
          phase_n  = '0;
          if (rw_r) begin
            x_n     = {spi_buffer[39:32], spi_buffer[47:40]};
            y_n     = {spi_buffer[23:16], spi_buffer[31:24]};
            z_n     = {spi_buffer[7:0],   spi_buffer[15:8]};
            valid_n = 1'b1;
          end else begin
            valid_n = 1'b0;
          end
        end else if (phase_r == PHASE_MAX) begin
          error_n  = 1'b1;
          enable_n = 1'b0;
          state_n  = ST_FAULT;
        end else begin
          phase_n = phase_r + PW'(1);
        end
      end
      ST_RELEASE: begin
        // The next command may only be raised once the master has dropped spi_ready.
        if (!spi_ready) begin
          if (!rw_r) begin
            idx_n = idx_r + 2'd1;
            if (idx_r == 2'd2) begin
              init_done_n = 1'b1;
              state_n     = run ? ST_SAMPLE_WAIT : ST_IDLE;
            end else if (run) begin
              state_n  = ST_ISSUE;
              enable_n = 1'b1;
              addr_n   = init_addr(idx_r + 2'd1);
              value_n  = init_value(idx_r + 2'd1);
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            state_n = run ? ST_SAMPLE_WAIT : ST_IDLE;
          end
        end else if (phase_r == PHASE_MAX) begin
          error_n  = 1'b1;
          enable_n = 1'b0;
          state_n  = ST_FAULT;
        end else begin
          phase_n = phase_r + PW'(1);
        end
      end
      ST_SAMPLE_WAIT: begin
        if (!run) begin
          state_n = ST_IDLE;
        end else if (pending_r) begin
          pend_clear_s = 1'b1;
          state_n      = ST_ISSUE;
          enable_n     = 1'b1;
          rw_n         = 1'b1;
          addr_n       = 6'h32;
          value_n      = 8'h00;
        end else begin
          state_n = ST_SAMPLE_WAIT;
        end
      end
      ST_FAULT: begin
        state_n  = ST_FAULT;
        enable_n = 1'b0;
      end
      default: begin
        state_n  = ST_IDLE;
        enable_n = 1'b0;
      end
    endcase

    tick_s = init_done_r && run;
    wrap_s = tick_s && (timer_r == TIMER_MAX);
    if (wrap_s) begin
      timer_n = '0;
    end else if (tick_s) begin
      timer_n = timer_r + TW'(1);
    end else begin
      timer_n = timer_r;
    end
    // A wrap coinciding with the read issue re-arms pending without counting an overrun.
    if (wrap_s) begin
      pending_n = 1'b1;
    end else if (pend_clear_s) begin
      pending_n = 1'b0;
    end else begin
      pending_n = pending_r;
    end
    if (wrap_s && pending_r && !pend_clear_s && (overrun_r != 8'hFF)) begin
      overrun_n = overrun_r + 8'd1;
    end else begin
      overrun_n = overrun_r;
    end
    busy_n = (state_n != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= 2'd0;
      timer_r     <= '0;
      phase_r     <= '0;
      pending_r   <= 1'b0;
      enable_r    <= 1'b0;
      rw_r        <= 1'b0;
      addr_r      <= 6'h00;
      value_r     <= 8'h00;
      overrun_r   <= 8'h00;
      x_r         <= 16'h0000;
      y_r         <= 16'h0000;
      z_r         <= 16'h0000;
      valid_r     <= 1'b0;
      init_done_r <= 1'b0;
      error_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      idx_r       <= idx_n;
      timer_r     <= timer_n;
      phase_r     <= phase_n;
      pending_r   <= pending_n;
      enable_r    <= enable_n;
      rw_r        <= rw_n;
      addr_r      <= addr_n;
      value_r     <= value_n;
      overrun_r   <= overrun_n;
      x_r         <= x_n;
      y_r         <= y_n;
      z_r         <= z_n;
      valid_r     <= valid_n;
      init_done_r <= init_done_n;
      error_r     <= error_n;
      busy_r      <= busy_n;
    end
  end

  assign spi_enable    = enable_r;
  assign spi_rw        = rw_r;
  assign spi_address   = addr_r;
  assign spi_value     = value_r;
  assign sample_x      = x_r;
  assign sample_y      = y_r;
  assign sample_z      = z_r;
  assign sample_valid  = valid_r;
  assign init_done     = init_done_r;
  assign busy          = busy_r;
  assign overrun_count = overrun_r;
  assign error         = error_r;

endmodule

// File: tb/tb_accel_sample_ctrl.sv
// Self-checking bench for accel_sample_ctrl: behavioural SPI slave, sample scoreboard,
// overrun model, and sequences for timeout, stop/resume and asynchronous reset.
module tb_accel_sample_ctrl;
  localparam int SDIV = 100;
  localparam int TMO  = 2000;

  logic        clk = 1'b0;
  logic        reset, run, spi_enable, spi_rw, spi_ready;
  logic [5:0]  spi_address;
  logic [7:0]  spi_value, overrun_count;
  logic [55:0] spi_buffer;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        sample_valid, init_done, busy, error;

  accel_sample_ctrl #(.SAMPLE_DIV(SDIV), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .run(run), .spi_enable(spi_enable), .spi_rw(spi_rw),
    .spi_address(spi_address), .spi_value(spi_value), .spi_buffer(spi_buffer),
    .spi_ready(spi_ready), .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .sample_valid(sample_valid), .init_done(init_done), .busy(busy),
    .overrun_count(overrun_count), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [55:0] rd_data; logic [15:0] x; logic [15:0] y; logic [15:0] z; } vec_t;
  typedef struct { logic rw; logic [5:0] addr; logic [7:0] val; } cmd_t;

  vec_t        tbl[4];
  vec_t        vec_q[$];
  cmd_t        log_q[$];
  logic [47:0] exp_q[$];

  int n_cmp = 0, n_bad = 0;
  int ack_delay = 40, rel_delay = 2, valid_cnt = 0, valid_target = 0;
  int reads_issued = 0, cyc_init = 0, stable_bad = 0, reen_bad = 0;
  bit never_ack = 1'b0, rand_delay = 1'b0, ovr_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Byte-level reassembly: DATAX0 is the highest of the six used bytes.
  function automatic logic [47:0] ref_samples(input logic [55:0] d);
    int unsigned b[6];
    logic [55:0] sh;
    logic [15:0] x, y, z;
    for (int k = 0; k < 6; k++) begin
      sh   = d >> (8 * (5 - k));
      b[k] = {24'd0, sh[7:0]};
    end
    x = 16'(b[1] * 256 + b[0]);
    y = 16'(b[3] * 256 + b[2]);
    z = 16'(b[5] * 256 + b[4]);
    return {x, y, z};
  endfunction

  // Behavioural SPI slave: logs each command, acks after a delay, drops ready later.
  initial begin : spi_model
    int   m_state, m_cnt, m_delay;
    cmd_t cur;
    vec_t v;
    m_state = 0; m_cnt = 0; m_delay = 0;
    spi_ready = 1'b0; spi_buffer = 56'd0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        spi_ready = 1'b0;
        m_state   = 0;
      end else begin
        case (m_state)
          0: if (spi_enable && !never_ack) begin
               cur.rw = spi_rw; cur.addr = spi_address; cur.val = spi_value;
               log_q.push_back(cur);
               if (spi_rw) reads_issued++;
               m_delay = rand_delay ? int'($urandom_range(90, 5)) : ack_delay;
               m_cnt = 1; m_state = 1;
             end
          1: begin
               if (spi_enable !== 1'b1 || spi_rw !== cur.rw || spi_address !== cur.addr ||
                   spi_value !== cur.val) stable_bad++;
               m_cnt++;
               if (m_cnt >= m_delay) begin
                 if (cur.rw) begin
                   if (vec_q.size() > 0) begin
                     v = vec_q.pop_front();
                     spi_buffer = v.rd_data;
                     exp_q.push_back({v.x, v.y, v.z});
                   end else begin
                     spi_buffer = {8'($urandom), 16'($urandom), 32'($urandom)};
                     exp_q.push_back(ref_samples(spi_buffer));
                   end
                 end
                 spi_ready = 1'b1;
                 m_state = 2;
               end
             end
          2: if (!spi_enable) begin m_cnt = 0; m_state = 3; end
          3: begin
               if (spi_enable) reen_bad++;
               m_cnt++;
               if (m_cnt >= rel_delay) begin spi_ready = 1'b0; m_state = 0; end
             end
          default: m_state = 0;
        endcase
      end
    end
  end

  // Sample scoreboard and overrun model (wraps since init, minus reads issued, minus pending).
  initial begin : monitor
    bit          init_prev, valid_prev;
    logic [47:0] e;
    int          eo;
    init_prev = 1'b0; valid_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        init_prev = 1'b0; valid_prev = 1'b0;
      end else begin
        if (init_done && !init_prev) begin
          cyc_init = cyc;
          reads_issued = 0;
        end
        init_prev = init_done;
        if (sample_valid) begin
          valid_cnt++;
          check("valid_pulse_width", 64'(valid_prev), 64'd0);
          check("exp_queue_depth", 64'(exp_q.size()), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sample_xyz", 64'({sample_x, sample_y, sample_z}), 64'(e));
          end
          if (ovr_en) begin
            eo = (cyc - cyc_init) / SDIV - reads_issued - 1;
            if (eo > 255) eo = 255;
            check("overrun_model", 64'(overrun_count), 64'(eo));
          end
        end
        valid_prev = sample_valid;
      end
    end
  end

  function automatic bit cond(input int sel);
    case (sel)
      0: return init_done;
      1: return !busy;
      2: return spi_enable && spi_rw;
      3: return error;
      4: return valid_cnt >= valid_target;
      5: return log_q.size() >= 2;
      6: return spi_enable;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input int budget, input string name);
    int n = 0;
    while (!cond(sel) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check(name, 64'(cond(sel)), 64'd1);
  endtask

  task automatic check_cmd(input string name, input int i, input logic rw,
                           input logic [5:0] a, input logic [7:0] v);
    if (i < log_q.size()) check(name, 64'({log_q[i].rw, log_q[i].addr, log_q[i].val}), 64'({rw, a, v}));
    else check({name, "_missing"}, 64'(log_q.size()), 64'(i + 1));
  endtask

  task automatic check_init_log(input string name);
    check_cmd({name, "_w0"}, 0, 1'b0, 6'h31, 8'h0B);
    check_cmd({name, "_w1"}, 1, 1'b0, 6'h2C, 8'h0F);
    check_cmd({name, "_w2"}, 2, 1'b0, 6'h2D, 8'h08);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b0;
    log_q.delete(); exp_q.delete(); vec_q.delete();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin : main
    int cyc_s, v0, en_seen;
    tbl[0] = '{56'h00_3412_7856_BC9A, 16'h1234, 16'h5678, 16'h9ABC};
    tbl[1] = '{56'hFF_0000_0000_0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[2] = '{56'h00_0080_FF7F_01FF, 16'h8000, 16'h7FFF, 16'hFF01};
    tbl[3] = '{56'hA5_FFFF_FFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

    reset = 1'b0; run = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_outputs", 64'({spi_enable, spi_rw, spi_address, spi_value, sample_valid,
                              init_done, busy, overrun_count, error}), 64'd0);
    check("rst_samples", 64'({sample_x, sample_y, sample_z}), 64'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 check("idle_without_run", 64'({busy, spi_enable}), 64'd0);

    // Init table written in order, nothing else before init_done.
    run = 1'b1;
    wait_cond(0, 2000, "init_done_wait");
    check("init_log_size", 64'(log_q.size()), 64'd3);
    check_init_log("init");
    check("busy_running", 64'(busy), 64'd1);

    // Table-driven reads.
    for (int i = 0; i < 4; i++) begin
      vec_q.push_back(tbl[i]);
      valid_target = valid_cnt + 1;
      wait_cond(4, 600, "tbl_valid_wait");
      check("tbl_x", 64'(sample_x), 64'(tbl[i].x));
      check("tbl_y", 64'(sample_y), 64'(tbl[i].y));
      check("tbl_z", 64'(sample_z), 64'(tbl[i].z));
    end

    // Randomized data and ack delays.
    rand_delay = 1'b1;
    valid_target = valid_cnt + 10;
    wait_cond(4, 10 * 300, "rand_valid_wait");
    rand_delay = 1'b0;
    for (int i = 3; i < log_q.size(); i++) check_cmd("read_cmd", i, 1'b1, 6'h32, 8'h00);

    // Slow acks: overruns accumulate, then saturate.
    ack_delay = 250;
    ovr_en = 1'b1;
    valid_target = valid_cnt + 4;
    wait_cond(4, 4 * 400, "ovr_valid_wait");
    check("overrun_nonzero", 64'(overrun_count != 8'd0), 64'd1);
    ack_delay = 1950;
    valid_target = valid_cnt + 18;
    wait_cond(4, 18 * 2100, "sat_valid_wait");
    check("overrun_saturated", 64'(overrun_count), 64'd255);
    ovr_en = 1'b0;
    check("cmd_stable", 64'(stable_bad), 64'd0);
    check("no_enable_while_ready", 64'(reen_bad), 64'd0);

    // Asynchronous reset in the middle of a read, then a full re-init.
    ack_delay = 40;
    wait_cond(2, 3000, "read_start_wait");
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_rst_outputs", 64'({spi_enable, spi_rw, spi_address, spi_value, sample_valid,
                                    init_done, busy, overrun_count, error}), 64'd0);
    check("async_rst_samples", 64'({sample_x, sample_y, sample_z}), 64'd0);
    log_q.delete(); exp_q.delete();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    wait_cond(0, 2000, "reinit_wait");
    check("reinit_log_size", 64'(log_q.size()), 64'd3);
    check_init_log("reinit");

    // Stop during the second init write, resume at the saved entry.
    do_reset();
    run = 1'b1;
    wait_cond(5, 1000, "entry1_wait");
    repeat (10) @(posedge clk);
    #2 check("entry1_in_flight", 64'({spi_enable, spi_address}), 64'({1'b1, 6'h2C}));
    run = 1'b0;
    wait_cond(1, 500, "stop_idle_wait");
    check("stop_log_size", 64'(log_q.size()), 64'd2);
    check("stop_not_init", 64'(init_done), 64'd0);
    repeat (20) @(posedge clk);
    #2 check("stopped_quiet", 64'({spi_enable, busy}), 64'd0);
    run = 1'b1;
    wait_cond(0, 1000, "resume_init_wait");
    check("resume_log_size", 64'(log_q.size()), 64'd3);
    check_init_log("resume");

    // Never-acked transfer: timeout, then terminal fault.
    do_reset();
    never_ack = 1'b1;
    run = 1'b1;
    wait_cond(6, 100, "fault_issue_wait");
    cyc_s = cyc;
    wait_cond(3, 2 * TMO, "error_wait");
    check("timeout_cycles", 64'(cyc - cyc_s), 64'(TMO + 1));
    check("fault_outputs", 64'({spi_enable, busy, error}), 64'({1'b0, 1'b1, 1'b1}));
    v0 = valid_cnt; en_seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 20) run = 1'b0;
      if (i == 40) run = 1'b1;
      @(posedge clk); #2;
      if (spi_enable || sample_valid) en_seen++;
    end
    check("fault_quiet", 64'(en_seen), 64'd0);
    check("fault_no_valid", 64'(valid_cnt), 64'(v0));
    check("fault_sticky", 64'({busy, error}), 64'({1'b1, 1'b1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
